// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequencing/decode unit: Moore FSM that drives every datapath
// load enable, bus gate, mux select and memory strobe through fetch/decode/execute.
module slc3_isdu #(
    parameter int MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [4:0] HALTED   = 5'd0;
    localparam logic [4:0] FETCH1   = 5'd1;
    localparam logic [4:0] FETCH_RD = 5'd2;
    localparam logic [4:0] FETCH3   = 5'd3;
    localparam logic [4:0] DECODE   = 5'd4;
    localparam logic [4:0] S_ADD    = 5'd5;
    localparam logic [4:0] S_AND    = 5'd6;
    localparam logic [4:0] S_NOT    = 5'd7;
    localparam logic [4:0] BR_CHK   = 5'd8;
    localparam logic [4:0] BR_TAKE  = 5'd9;
    localparam logic [4:0] S_JMP    = 5'd10;
    localparam logic [4:0] JSR1     = 5'd11;
    localparam logic [4:0] JSR2     = 5'd12;
    localparam logic [4:0] LDR1     = 5'd13;
    localparam logic [4:0] LDR_RD   = 5'd14;
    localparam logic [4:0] LDR3     = 5'd15;
    localparam logic [4:0] STR1     = 5'd16;
    localparam logic [4:0] STR2     = 5'd17;
    localparam logic [4:0] STR_WR   = 5'd18;
    localparam logic [4:0] PAUSE1   = 5'd19;
    localparam logic [4:0] PAUSE2   = 5'd20;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    logic [4:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;

    function automatic logic is_mem(input logic [4:0] s);
        return (s == FETCH_RD) || (s == LDR_RD) || (s == STR_WR);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:   if (Run) state_d = FETCH1;
            FETCH1:   state_d = FETCH_RD;
            FETCH_RD: if (wait_q == 4'd0) state_d = FETCH3;
            FETCH3:   state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = BR_CHK;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = JSR1;
                    4'b0110: state_d = LDR1;
                    4'b0111: state_d = STR1;
                    4'b1101: state_d = PAUSE1;
                    default: state_d = FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_JMP, BR_TAKE, JSR2, LDR3: state_d = FETCH1;
            BR_CHK:   state_d = BEN ? BR_TAKE : FETCH1;
            JSR1:     state_d = JSR2;
            LDR1:     state_d = LDR_RD;
            LDR_RD:   if (wait_q == 4'd0) state_d = LDR3;
            STR1:     state_d = STR2;
            STR2:     state_d = STR_WR;
            STR_WR:   if (wait_q == 4'd0) state_d = FETCH1;
            PAUSE1:   if (Continue) state_d = PAUSE2;
            PAUSE2:   if (!Continue) state_d = FETCH1;
            default:  state_d = HALTED;
        endcase
    end

    // Memory states are never entered from one another, so entry is a non-mem -> mem edge.
    always_comb begin
        wait_d = wait_q;
        if (is_mem(state_d) && !is_mem(state_q)) begin
            wait_d = WAIT_INIT;
        end else if (is_mem(state_q) && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        case (state_q)
            FETCH1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
            end
            FETCH_RD, LDR_RD: begin
                Mem_OE = 1'b1;
                LD_MDR = (wait_q == 4'd0);
            end
            FETCH3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR1MUX = 1'b1; SR2MUX = IR_5; DRMUX = 1'b0;
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state_q == S_ADD) ? 2'b00 : (state_q == S_AND) ? 2'b01 : 2'b10;
            end
            BR_TAKE: begin
                ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            S_JMP: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            JSR1: begin
                DRMUX = 1'b1; GatePC = 1'b1; LD_REG = 1'b1;
            end
            JSR2: begin
                ADDR1MUX = 1'b0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            LDR1, STR1: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            LDR3: begin
                DRMUX = 1'b0; GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            STR2: begin
                SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            STR_WR: Mem_WE = 1'b1;
            PAUSE1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_isdu.sv
// Directed bench for slc3_isdu: main instance at MEM_WAIT=3, second at MEM_WAIT=1.
module tb_slc3_isdu;
    localparam int W = 3;

    logic Clk, Reset, Run, Continue, IR_5, BEN;
    logic [3:0] Opcode;

    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;

    logic b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_BEN, b_LD_CC, b_LD_REG, b_LD_PC, b_LD_LED;
    logic b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX, b_DRMUX, b_SR1MUX, b_SR2MUX, b_ADDR1MUX;
    logic b_Mem_OE, b_Mem_WE;
    logic [1:0] b_PCMUX, b_ADDR2MUX, b_ALUK;

    logic [24:0] o0;
    assign o0 = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                 GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                 ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    int tests = 0;
    int fails = 0;

    slc3_isdu #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
        .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    slc3_isdu #(.MEM_WAIT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .BEN(BEN), .LD_MAR(b_LD_MAR), .LD_MDR(b_LD_MDR), .LD_IR(b_LD_IR),
        .LD_BEN(b_LD_BEN), .LD_CC(b_LD_CC), .LD_REG(b_LD_REG), .LD_PC(b_LD_PC),
        .LD_LED(b_LD_LED), .GatePC(b_GatePC), .GateMDR(b_GateMDR), .GateALU(b_GateALU),
        .GateMARMUX(b_GateMARMUX), .PCMUX(b_PCMUX), .DRMUX(b_DRMUX), .SR1MUX(b_SR1MUX),
        .SR2MUX(b_SR2MUX), .ADDR1MUX(b_ADDR1MUX), .ADDR2MUX(b_ADDR2MUX), .ALUK(b_ALUK),
        .Mem_OE(b_Mem_OE), .Mem_WE(b_Mem_WE)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // From FETCH1, advance the W=3 instance to DECODE.
    task automatic run_fetch();
        repeat (W + 2) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0;
        tick(); tick();
        tests++; if (o0 !== 25'd0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", o0); end
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++; if (o0 !== 25'd0) begin fails++; $display("FAIL halted_hold[%0d] got=%h exp=0", i, o0); end
        end
        Run = 1'b1; tick(); Run = 1'b0;
        tests++; if ({GatePC, LD_MAR, LD_PC, PCMUX, Mem_OE} !== 6'b111000) begin
            fails++; $display("FAIL fetch1_after_run got=%b exp=111000", {GatePC, LD_MAR, LD_PC, PCMUX, Mem_OE});
        end
    endtask

    task automatic test_alu();
        Opcode = 4'b0001; IR_5 = 1'b1;
        for (int i = 0; i < W; i++) begin
            tick();
            tests++; if ({Mem_OE, LD_MDR} !== {1'b1, (i == W - 1)}) begin
                fails++; $display("FAIL fetch_rd[%0d] oe_mdr got=%b%b exp=1%b", i, Mem_OE, LD_MDR, (i == W - 1));
            end
        end
        tick();
        tests++; if ({LD_IR, GateMDR, Mem_OE, LD_MDR} !== 4'b1100) begin
            fails++; $display("FAIL fetch3 got=%b exp=1100", {LD_IR, GateMDR, Mem_OE, LD_MDR});
        end
        tick();
        tests++; if ({LD_BEN, LD_IR} !== 2'b10) begin fails++; $display("FAIL decode_ld_ben got=%b exp=10", {LD_BEN, LD_IR}); end
        tick();
        tests++; if ({SR1MUX, SR2MUX, DRMUX, ALUK, GateALU, LD_REG, LD_CC} !== 8'b11000111) begin
            fails++; $display("FAIL add_exec got=%b exp=11000111", {SR1MUX, SR2MUX, DRMUX, ALUK, GateALU, LD_REG, LD_CC});
        end
        tick();
        tests++; if ({GatePC, LD_MAR, GateALU} !== 3'b110) begin
            fails++; $display("FAIL add_next_fetch_7cyc got=%b exp=110", {GatePC, LD_MAR, GateALU});
        end
        Opcode = 4'b0101; IR_5 = 1'b0;
        run_fetch(); tick();
        tests++; if ({ALUK, SR2MUX, GateALU, LD_CC} !== 5'b01011) begin
            fails++; $display("FAIL and_exec got=%b exp=01011", {ALUK, SR2MUX, GateALU, LD_CC});
        end
        tick();
        Opcode = 4'b1001;
        run_fetch(); tick();
        tests++; if ({ALUK, GateALU, LD_REG} !== 4'b1011) begin
            fails++; $display("FAIL not_exec got=%b exp=1011", {ALUK, GateALU, LD_REG});
        end
        tick();
        Opcode = 4'b1000;
        run_fetch(); tick();
        tests++; if ({GatePC, LD_MAR, LD_PC} !== 3'b111) begin
            fails++; $display("FAIL unknown_op_to_fetch got=%b exp=111", {GatePC, LD_MAR, LD_PC});
        end
    endtask

    task automatic test_branch();
        Opcode = 4'b0000; BEN = 1'b0;
        run_fetch(); tick();
        tests++; if (o0 !== 25'd0) begin fails++; $display("FAIL br_chk_idle got=%h exp=0", o0); end
        tick();
        tests++; if ({GatePC, LD_PC, PCMUX} !== 4'b1100) begin
            fails++; $display("FAIL br_not_taken got=%b exp=1100", {GatePC, LD_PC, PCMUX});
        end
        BEN = 1'b1;
        run_fetch(); tick(); tick();
        tests++; if ({LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, GatePC} !== 7'b1100100) begin
            fails++; $display("FAIL br_taken got=%b exp=1100100", {LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, GatePC});
        end
        tick();
        BEN = 1'b0;
        tests++; if ({GatePC, LD_MAR} !== 2'b11) begin fails++; $display("FAIL br_taken_next_fetch got=%b exp=11", {GatePC, LD_MAR}); end
    endtask

    task automatic test_jmp_jsr();
        Opcode = 4'b1100;
        run_fetch(); tick();
        tests++; if ({LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX} !== 7'b1101001) begin
            fails++; $display("FAIL jmp got=%b exp=1101001", {LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX});
        end
        tick();
        Opcode = 4'b0100;
        run_fetch(); tick();
        tests++; if ({DRMUX, GatePC, LD_REG, LD_PC, LD_MAR} !== 5'b11100) begin
            fails++; $display("FAIL jsr1 got=%b exp=11100", {DRMUX, GatePC, LD_REG, LD_PC, LD_MAR});
        end
        tick();
        tests++; if ({LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, LD_REG} !== 7'b1100110) begin
            fails++; $display("FAIL jsr2 got=%b exp=1100110", {LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, LD_REG});
        end
        tick();
    endtask

    task automatic test_ldr();
        Opcode = 4'b0110;
        run_fetch(); tick();
        tests++; if ({GateMARMUX, LD_MAR, ADDR1MUX, ADDR2MUX, SR1MUX, Mem_OE} !== 7'b1110110) begin
            fails++; $display("FAIL ldr1 got=%b exp=1110110", {GateMARMUX, LD_MAR, ADDR1MUX, ADDR2MUX, SR1MUX, Mem_OE});
        end
        for (int i = 0; i < W; i++) begin
            tick();
            tests++; if ({Mem_OE, LD_MDR} !== {1'b1, (i == W - 1)}) begin
                fails++; $display("FAIL ldr_rd[%0d] got=%b%b exp=1%b", i, Mem_OE, LD_MDR, (i == W - 1));
            end
        end
        tick();
        tests++; if ({GateMDR, LD_REG, LD_CC, DRMUX, Mem_OE} !== 5'b11100) begin
            fails++; $display("FAIL ldr3 got=%b exp=11100", {GateMDR, LD_REG, LD_CC, DRMUX, Mem_OE});
        end
        tick();
    endtask

    task automatic test_str();
        Opcode = 4'b0111;
        run_fetch(); tick();
        tests++; if ({GateMARMUX, LD_MAR, ADDR2MUX} !== 4'b1101) begin
            fails++; $display("FAIL str1 got=%b exp=1101", {GateMARMUX, LD_MAR, ADDR2MUX});
        end
        tick();
        tests++; if ({GateALU, LD_MDR, ALUK, SR1MUX, Mem_WE} !== 6'b111100) begin
            fails++; $display("FAIL str2 got=%b exp=111100", {GateALU, LD_MDR, ALUK, SR1MUX, Mem_WE});
        end
        for (int i = 0; i < W; i++) begin
            tick();
            tests++; if ({Mem_WE, Mem_OE} !== 2'b10) begin
                fails++; $display("FAIL str_wr[%0d] we_oe got=%b exp=10", i, {Mem_WE, Mem_OE});
            end
        end
        tick();
        tests++; if ({Mem_WE, GatePC} !== 2'b01) begin fails++; $display("FAIL str_end got=%b exp=01", {Mem_WE, GatePC}); end
    endtask

    task automatic test_pause();
        Opcode = 4'b1101; Continue = 1'b0;
        run_fetch(); tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++; if ({LD_LED, GatePC} !== 2'b10) begin
                fails++; $display("FAIL pause_hold[%0d] got=%b exp=10", i, {LD_LED, GatePC});
            end
        end
        Continue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if ({LD_LED, GatePC} !== 2'b00) begin
                fails++; $display("FAIL pause2_hold[%0d] got=%b exp=00", i, {LD_LED, GatePC});
            end
        end
        Continue = 1'b0; tick();
        tests++; if ({GatePC, LD_MAR} !== 2'b11) begin fails++; $display("FAIL pause_release got=%b exp=11", {GatePC, LD_MAR}); end
        run_fetch();
        Continue = 1'b1; tick();
        tests++; if (LD_LED !== 1'b1) begin fails++; $display("FAIL pause_held_entry got=%b exp=1", LD_LED); end
        tick();
        tests++; if ({LD_LED, GatePC} !== 2'b00) begin fails++; $display("FAIL pause_held_wait got=%b exp=00", {LD_LED, GatePC}); end
        Continue = 1'b0; tick();
        tests++; if ({GatePC, LD_MAR} !== 2'b11) begin fails++; $display("FAIL pause_held_release got=%b exp=11", {GatePC, LD_MAR}); end
    endtask

    task automatic test_reset_mid_access();
        Opcode = 4'b0110;
        run_fetch(); tick(); tick(); tick();
        tests++; if (Mem_OE !== 1'b1) begin fails++; $display("FAIL ldr_rd2_oe got=%b exp=1", Mem_OE); end
        Reset = 1'b1; tick(); Reset = 1'b0;
        tests++; if (o0 !== 25'd0) begin fails++; $display("FAIL reset_mid_ldr got=%h exp=0", o0); end
        tick();
        tests++; if (o0 !== 25'd0) begin fails++; $display("FAIL halted_after_mid_reset got=%h exp=0", o0); end
        Run = 1'b1; tick(); Run = 1'b0;
        tick();
        tests++; if ({b_Mem_OE, b_LD_MDR} !== 2'b11) begin
            fails++; $display("FAIL w1_fetch_rd got=%b exp=11", {b_Mem_OE, b_LD_MDR});
        end
        tick();
        tests++; if ({b_Mem_OE, b_LD_IR} !== 2'b01) begin fails++; $display("FAIL w1_fetch3 got=%b exp=01", {b_Mem_OE, b_LD_IR}); end
        tick(); tick();
        tests++; if (b_GateMARMUX !== 1'b1) begin fails++; $display("FAIL w1_ldr1 got=%b exp=1", b_GateMARMUX); end
        tick();
        tests++; if ({b_Mem_OE, b_LD_MDR} !== 2'b11) begin fails++; $display("FAIL w1_ldr_rd got=%b exp=11", {b_Mem_OE, b_LD_MDR}); end
        tick();
        tests++; if ({b_Mem_OE, b_LD_REG, b_GateMDR} !== 3'b011) begin
            fails++; $display("FAIL w1_ldr3 got=%b exp=011", {b_Mem_OE, b_LD_REG, b_GateMDR});
        end
        tick();
        tests++; if ({b_GatePC, b_LD_MAR} !== 2'b11) begin fails++; $display("FAIL w1_next_fetch got=%b exp=11", {b_GatePC, b_LD_MAR}); end
    endtask

    initial begin
        Clk = 1'b0; Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; BEN = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_jmp_jsr();
        test_ldr();
        test_str();
        test_pause();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
